cache_miss_ctrl: RTL

Miss-handling controller sitting directly downstream of the 4-way data cache, between it and main data memory. On a cache miss it stalls the pipeline, writes back a dirty victim, fetches the missing word over a req/ack memory port, and drives a one-cycle fill into the cache. It also keeps a saturating miss counter for performance measurement. Lines are one 32-bit word: 16 sets, 26-bit tag.

---
 rtl/cache_pkg.sv | 36 +++
 rtl/cache_miss_ctrl_sat_counter.sv | 30 +++
 rtl/cache_miss_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: geometry constants, miss-controller state encoding and address
// field helpers shared by the data cache and its miss controller.
// Build option: CACHE_WRITEBACK_EN selects write-back (defined) or
// write-through (undefined, default) store handling.
package cache_pkg;

  localparam int SET_BITS   = 4;
  localparam int TAG_BITS   = 26;
  localparam int DATA_WIDTH = 32;

`ifdef CACHE_WRITEBACK_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  // WTHRU is only entered in the write-through build; WRITEBACK only in write-back.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITEBACK = 3'd1,
    ST_REFILL    = 3'd2,
    ST_FILL      = 3'd3,
    ST_WTHRU     = 3'd4
  } miss_state_t;

  // Set index lives in address[5:2]: one 32-bit word per line.
  function automatic logic [SET_BITS-1:0] set_of(input logic [31:0] addr);
    return addr[SET_BITS+1:2];
  endfunction

  // Tag is everything above the set index.
  function automatic logic [TAG_BITS-1:0] tag_of(input logic [31:0] addr);
    return addr[31:SET_BITS+2];
  endfunction

endpackage

// File: rtl/cache_miss_ctrl_sat_counter.sv
// sat_counter: free-running event counter that sticks at all-ones instead
// of wrapping, cleared by synchronous reset.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  // Increment on request unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl: services data-cache misses. Stalls the pipeline, writes
// back a dirty victim, fetches the missing word from memory and issues a
// one-cycle fill into the cache. Counts accepted misses (saturating).
// Build option: CACHE_WRITEBACK_EN. When undefined every store is written
// through to memory (WTHRU) and dirty victims are never written back.
//
// Memory handshake: mem_req_o together with mem_we_o/mem_addr_o/mem_wdata_o
// is held constant until mem_ack_i is sampled high on a rising edge; that
// edge completes the request (and delivers mem_rdata_i on reads). mem_ack_i
// while mem_req_o is low has no effect.
module cache_miss_ctrl
  import cache_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  input  logic                req_write_i,
  input  logic [31:0]         req_addr_i,
  input  logic [31:0]         req_wdata_i,
  input  logic                hit_i,
  input  logic                victim_valid_i,
  input  logic                victim_dirty_i,
  input  logic [TAG_BITS-1:0] victim_tag_i,
  input  logic [31:0]         victim_data_i,
  output logic                stall_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [31:0]         mem_addr_o,
  output logic [31:0]         mem_wdata_o,
  input  logic                mem_ack_i,
  input  logic [31:0]         mem_rdata_i,
  output logic                fill_we_o,
  output logic [31:0]         fill_addr_o,
  output logic [31:0]         fill_data_o,
  output logic [31:0]         miss_count_o
);

  miss_state_t         state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic                write_q, write_d;
  logic                is_miss_q, is_miss_d;
  logic [31:0]         data_q, data_d;    // store data, replaced by refill data on loads
  logic [TAG_BITS-1:0] vtag_q, vtag_d;
  logic [31:0]         vdata_q, vdata_d;

  logic miss;
  logic start;
  logic dirty_victim;
  logic count_inc;

  assign miss         = req_valid_i && !hit_i;
  assign dirty_victim = WB_EN && victim_valid_i && victim_dirty_i;

`ifdef CACHE_WRITEBACK_EN
  // Store hits are absorbed by the cache; only misses need the controller.
  assign start = miss;
`else
  // Every store must also reach memory, so store hits start a transaction too.
  assign start = miss || (req_valid_i && req_write_i);
`endif

  // Next-state, request capture and output decode.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    write_d     = write_q;
    is_miss_d   = is_miss_q;
    data_d      = data_q;
    vtag_d      = vtag_q;
    vdata_d     = vdata_q;
    count_inc   = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    fill_we_o   = 1'b0;
    fill_addr_o = '0;
    fill_data_o = '0;
    stall_o     = (state_q != ST_IDLE) || start;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d    = req_addr_i;
          write_d   = req_write_i;
          is_miss_d = miss;
          data_d    = req_wdata_i;
          vtag_d    = victim_tag_i;
          vdata_d   = victim_data_i;
          count_inc = miss;
          if (req_write_i && !WB_EN) state_d = ST_WTHRU;
          else if (dirty_victim)     state_d = ST_WRITEBACK;
          else if (req_write_i)      state_d = ST_FILL;
          else                       state_d = ST_REFILL;
        end
      end
      ST_WRITEBACK: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {vtag_q, set_of(addr_q), 2'b00};
        mem_wdata_o = vdata_q;
        if (mem_ack_i) state_d = write_q ? ST_FILL : ST_REFILL;
      end
      ST_REFILL: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {addr_q[31:2], 2'b00};
        if (mem_ack_i) begin
          data_d  = mem_rdata_i;
          state_d = ST_FILL;
        end
      end
      ST_WTHRU: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = addr_q;
        mem_wdata_o = data_q;
        if (mem_ack_i) state_d = is_miss_q ? ST_FILL : ST_IDLE;
      end
      ST_FILL: begin
        fill_we_o   = 1'b1;
        fill_addr_o = addr_q;
        fill_data_o = data_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched-request registers; reset abandons any open request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      is_miss_q <= 1'b0;
      data_q    <= '0;
      vtag_q    <= '0;
      vdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      is_miss_q <= is_miss_d;
      data_q    <= data_d;
      vtag_q    <= vtag_d;
      vdata_q   <= vdata_d;
    end
  end

  sat_counter #(.WIDTH(32)) u_miss_count (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (count_inc),
    .count_o (miss_count_o)
  );

endmodule
